// File: rtl/audio_echo_effect_if.sv
// rtl/audio_echo_effect_if.sv - capture/playback FIFO handshake bundle for the echo stage
interface audio_echo_effect_if #(
  parameter int AUDIO_DATA_WIDTH = 32
);
  logic                        audio_in_available;
  logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_in;
  logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_in;
  logic                        read_audio_in;
  logic                        audio_out_allowed;
  logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_out;
  logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_out;
  logic                        write_audio_out;

  // echo stage side: pops capture FIFOs, pushes playback FIFOs
  modport master (
    input  audio_in_available, left_channel_audio_in, right_channel_audio_in, audio_out_allowed,
    output read_audio_in, left_channel_audio_out, right_channel_audio_out, write_audio_out
  );

  // FIFO side
  modport slave (
    output audio_in_available, left_channel_audio_in, right_channel_audio_in, audio_out_allowed,
    input  read_audio_in, left_channel_audio_out, right_channel_audio_out, write_audio_out
  );
endinterface

// File: rtl/audio_echo_effect.sv
// rtl/audio_echo_effect.sv - stereo feedback echo with saturating mix and per-channel delay RAM
module audio_echo_effect #(
  parameter int AUDIO_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH       = 12
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  effect_enable,
  input  logic [ADDR_WIDTH-1:0] delay_samples,
  input  logic [2:0]            atten_shift,
  input  logic                  clear_delay,
  output logic                  busy_clearing,
  audio_echo_effect_if.master   audio
);
  localparam int W = AUDIO_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_MEM_RD, S_MEM_WAIT, S_CALC, S_WAIT_OUT
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] clr_addr, wr_ptr, rd_addr, ram_waddr;
  logic [W-1:0] in_l, in_r, out_l, out_r, rd_l, rd_r, ram_wdata_l, ram_wdata_r;
  logic read_pulse, write_pulse, ram_we, rd_en;

  logic [W-1:0] mem_l [2**ADDR_WIDTH];
  logic [W-1:0] mem_r [2**ADDR_WIDTH];

  // in + (delayed >>> sh) one bit wider, clamped to the signed sample range
  function automatic logic [W-1:0] mix(input logic [W-1:0] x, input logic [W-1:0] d,
                                        input logic [2:0] sh);
    logic signed [W-1:0] ds;
    logic signed [W:0]   sum;
    ds  = $signed(d) >>> sh;
    sum = $signed({x[W-1], x}) + $signed({ds[W-1], ds});
    if (sum[W] != sum[W-1])
      mix = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      mix = sum[W-1:0];
  endfunction

  // delay 0 wraps onto wr_ptr itself, i.e. the oldest stored sample
  assign rd_addr = wr_ptr - delay_samples;

  // state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_CLEAR;
    else       state <= next_state;
  end

  // next-state decode, handshake pulses and RAM write-port steering
  always_comb begin
    next_state    = state;
    read_pulse    = 1'b0;
    write_pulse   = 1'b0;
    busy_clearing = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = wr_ptr;
    ram_wdata_l   = out_l;
    ram_wdata_r   = out_r;
    rd_en         = 1'b0;
    case (state)
      S_CLEAR: begin
        busy_clearing = 1'b1;
        ram_we        = 1'b1;
        ram_waddr     = clr_addr;
        ram_wdata_l   = '0;
        ram_wdata_r   = '0;
        if (clr_addr == '1) next_state = S_IDLE;
      end
      S_IDLE: begin
        if (clear_delay) begin
          next_state = S_CLEAR;
        end else if (audio.audio_in_available) begin
          read_pulse = 1'b1;
          next_state = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        rd_en      = 1'b1;
        next_state = S_MEM_WAIT;
      end
      S_MEM_WAIT: next_state = S_CALC;
      S_CALC:     next_state = S_WAIT_OUT;
      S_WAIT_OUT: begin
        if (audio.audio_out_allowed) begin
          write_pulse = 1'b1;
          ram_we      = 1'b1;
          next_state  = S_IDLE;
        end
      end
      default: next_state = S_CLEAR;
    endcase
  end

  // pointers, input latch and output mix registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clr_addr <= '0;
      wr_ptr   <= '0;
      in_l     <= '0;
      in_r     <= '0;
      out_l    <= '0;
      out_r    <= '0;
    end else begin
      if (state == S_CLEAR) clr_addr <= clr_addr + 1'b1;
      if (state == S_IDLE && clear_delay) begin
        clr_addr <= '0;
        wr_ptr   <= '0;
      end
      if (read_pulse) begin
        in_l <= audio.left_channel_audio_in;
        in_r <= audio.right_channel_audio_in;
      end
      if (state == S_CALC) begin
        out_l <= effect_enable ? mix(in_l, rd_l, atten_shift) : in_l;
        out_r <= effect_enable ? mix(in_r, rd_r, atten_shift) : in_r;
      end
      if (write_pulse) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // delay RAMs: one write port, one registered read port each
  always_ff @(posedge CLOCK_50) begin
    if (ram_we) begin
      mem_l[ram_waddr] <= ram_wdata_l;
      mem_r[ram_waddr] <= ram_wdata_r;
    end
    if (rd_en) begin
      rd_l <= mem_l[rd_addr];
      rd_r <= mem_r[rd_addr];
    end
  end

  assign audio.read_audio_in           = read_pulse;
  assign audio.write_audio_out         = write_pulse;
  assign audio.left_channel_audio_out  = out_l;
  assign audio.right_channel_audio_out = out_r;
endmodule
